// File: rtl/em_74191.sv
// rtl/em_74191.sv - 74191/74190 style presettable up/down counter with synchronous load.
// Define EM_TTL_SATURATE_EN to make counting saturate at the terminal values instead of wrapping.
module em_74191 #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             nload,
  input  logic             nenable,
  input  logic             down,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] count,
  output logic             max_min,
  output logic             nrco
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  // One extra bit so "count >= MODULUS" stays meaningful when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH + 1)'(MODULUS - 1);

`ifdef EM_TTL_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_WRAP   = TOP;
  localparam logic [WIDTH-1:0] DOWN_WRAP = '0;
`else
  localparam logic [WIDTH-1:0] UP_WRAP   = '0;
  localparam logic [WIDTH-1:0] DOWN_WRAP = TOP;
`endif

  logic [WIDTH:0]   count_ext;
  logic [WIDTH-1:0] count_next;

  assign count_ext = {1'b0, count};

  always_comb begin
    count_next = count;
    if (!nload) begin
      count_next = parallel_in;
    end else if (!nenable) begin
      if (!down) begin
        if (count_ext >= TOP_EXT) count_next = UP_WRAP;
        else                      count_next = count + WIDTH'(1);
      end else begin
        // Invalid states land on the top value in both build variants.
        if (count_ext >= MOD_EXT)   count_next = TOP;
        else if (count == '0)       count_next = DOWN_WRAP;
        else                        count_next = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) count <= '0;
    else       count <= count_next;
  end

  assign max_min = (!down && (count == TOP)) || (down && (count == '0));
  assign nrco    = !(max_min && !nenable && !clk);

endmodule

// File: tb/tb_em_74191.sv
// tb/tb_em_74191.sv - scoreboard bench for em_74191, binary (16) and BCD (10) instances side by side.
module tb_em_74191;

`ifdef EM_TTL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nclr, nload, nenable, down;
  logic [3:0] parallel_in;
  logic [3:0] count16, count10;
  logic       max_min16, max_min10, nrco16, nrco10;

  int n_checks = 0;
  int n_pass   = 0;
  int m16 = 0;
  int m10 = 0;
  int q16[$];
  int q10[$];

  always #5 clk = ~clk;

  em_74191 #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .nclr(nclr), .nload(nload), .nenable(nenable), .down(down),
    .parallel_in(parallel_in), .count(count16), .max_min(max_min16), .nrco(nrco16)
  );

  em_74191 #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .nclr(nclr), .nload(nload), .nenable(nenable), .down(down),
    .parallel_in(parallel_in), .count(count10), .max_min(max_min10), .nrco(nrco10)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_next(int c, int md, bit nl, bit ne, bit dn, int pin);
    if (!nl) return pin;
    if (ne) return c;
    if (!dn) begin
      if (c >= md - 1) return SAT ? md - 1 : 0;
      return c + 1;
    end
    if (c >= md) return md - 1;
    if (c == 0) return SAT ? 0 : md - 1;
    return c - 1;
  endfunction

  function automatic bit model_mm(int c, int md, bit dn);
    return (!dn && c == md - 1) || (dn && c == 0);
  endfunction

  task automatic check_flags(input string tag);
    bit mm16, mm10;
    mm16 = model_mm(m16, 16, down);
    mm10 = model_mm(m10, 10, down);
    check({tag, " max_min16"}, int'(max_min16), int'(mm16));
    check({tag, " max_min10"}, int'(max_min10), int'(mm10));
    check({tag, " nrco16"}, int'(nrco16), int'(!(mm16 && !nenable && !clk)));
    check({tag, " nrco10"}, int'(nrco10), int'(!(mm10 && !nenable && !clk)));
  endtask

  // Push expectations, take one edge, pop and compare, then check flags in both clock phases.
  task automatic step(input string tag);
    int e;
    q16.push_back(model_next(m16, 16, nload, nenable, down, int'(parallel_in)));
    q10.push_back(model_next(m10, 10, nload, nenable, down, int'(parallel_in)));
    @(posedge clk);
    #1;
    e = q16.pop_front();
    check({tag, " count16"}, int'(count16), e);
    m16 = e;
    e = q10.pop_front();
    check({tag, " count10"}, int'(count10), e);
    m10 = e;
    check_flags({tag, " hi"});
    @(negedge clk);
    #1;
    check_flags({tag, " lo"});
  endtask

  task automatic drive(input bit nl, input bit ne, input bit dn, input int pin);
    nload = nl; nenable = ne; down = dn; parallel_in = 4'(pin);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nclr = 1'b0;
    drive(1, 1, 0, 0);
    #12;
    check("reset count16", int'(count16), 0);
    check("reset count10", int'(count10), 0);
    check_flags("reset");
    nclr = 1'b1;
    @(negedge clk); #1;

    // Load wins over count when both are asserted; then hold.
    drive(0, 0, 0, 3);  step("load3");
    drive(0, 0, 0, 6);  step("load_wins");
    drive(1, 1, 0, 0);  step("hold");

    // Asynchronous clear between edges, then first edge counts from zero.
    drive(0, 1, 0, 9);  step("load9");
    drive(1, 1, 0, 0);
    nclr = 1'b0;
    #1;
    check("async clr count16", int'(count16), 0);
    check("async clr count10", int'(count10), 0);
    m16 = 0; m10 = 0;
    check_flags("async clr");
    nclr = 1'b1;
    #1;
    drive(1, 0, 0, 0);  step("after clr");

    // Up count through both terminal counts and wrap.
    drive(0, 1, 0, 0);  step("load0");
    drive(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step($sformatf("up%0d", i));

    // Direction change at terminal count between edges.
    drive(0, 1, 0, 15); step("load15");
    drive(1, 1, 0, 0);
    check_flags("dir pre");
    down = 1'b1;
    #1;
    check_flags("dir post");
    drive(1, 0, 1, 0);  step("down after toggle");

    // Down count through zero, plus invalid-state recovery.
    drive(0, 1, 1, 2);  step("load2");
    drive(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) step($sformatf("down%0d", i));
    drive(0, 1, 0, 13); step("load13a");
    drive(1, 0, 0, 0);  step("up from 13");
    drive(0, 1, 1, 13); step("load13b");
    drive(1, 0, 1, 0);  step("down from 13");
    drive(0, 1, 1, 0);  step("load0 down");
    drive(1, 0, 1, 0);  step("down at 0");
    step("down at 0 again");

    // Randomised mix of controls.
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15));
      step($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
